alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU in the pipelined CPU's EX stage.
- Keeps the OR/ADD/SUB/CMP semantics and adds AND, XOR, an iterative unsigned MUL and an iterative unsigned DIV.
- Uses a valid/ready start handshake, a one-cycle done pulse, and registered result and flags.
- The EX-stage hazard unit stalls the pipe while in_ready is low.

Parameters:
- N, 32: operand/result width, >=4.
- CNT_W, $clog2(N)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; in_ready = (state==IDLE).
- alu_op  in  3  opcode, see Behaviour.
- input_1  in  N  operand A (dividend / multiplicand).
- input_2  in  N  operand B (divisor / multiplier).
- output_0  out  N  result low word / quotient.
- output_hi  out  N  MUL high word / DIV remainder; 0 for other ops.
- done  out  1  one-cycle pulse; output_* and flags valid from this cycle until the next done.
- zero_flag  out  1  result==0 (CMP: A==B).
- negative_flag  out  1  output_0[N-1] (CMP: A<B unsigned).
- carry_flag  out  1  ADD carry-out, SUB borrow; 0 otherwise.
- div0_flag  out  1  DIV with B==0.

Behaviour:
- Opcodes:
  - 000 OR, 001 ADD, 010 SUB, 011 CMP.
  - 100 AND, 101 XOR.
  - 110 MUL: {output_hi, output_0} = A*B, 2N bits.
  - 111 DIV: unsigned restoring division.
- Reset: state=IDLE; all outputs and flags 0; in_ready=1 from the cycle after reset deasserts.
- Accept: in_valid & in_ready sampled at edge E0; operands and op are latched at E0. Input changes after E0 have no effect.
- Simple ops (000-101):
  - Result and flags registered at E0; done=1 in the cycle after E0 (latency 1).
  - State stays IDLE, so back-to-back issue at 1 op/cycle.
- CMP: output_0 = 0 if A==B, all-ones if A<B, 1 if A>B (unsigned). zero_flag=eq, negative_flag=lt.
- Flags are updated by every op, including CMP.
- ADD/SUB wrap modulo 2^N.
- State machine IDLE -> ITER -> IDLE:
  - MUL/DIV move IDLE->ITER at E0 and load counter=N.
  - One shift-add (MUL) or shift-subtract (DIV) step per edge; counter decrements per step.
  - At edge EN the last step completes and the result and flags are registered; ITER->IDLE.
  - done=1 in the cycle after EN (latency N+1).
  - in_ready=0 from after E0 through EN; it is 1 in the done cycle, so a new op may be accepted in that cycle.
- MUL flags: zero/negative derived from the low word only.
- DIV by zero: detected at E0, no iteration. output_0=all-ones, output_hi=A, div0_flag=1, done after latency 1.
- in_valid while in_ready=0 is ignored and not queued.
- done and flags are never asserted without a prior accept.
- Reset mid-ITER aborts: IDLE, outputs 0, no done pulse.
- Reset has priority over accept in the same cycle.
- Opcode with X/undefined bits is not supported (verification must not drive it).

Optional Feature:
- ALU_DIV_EN
- Defined: DIV as above, using the shared iterative datapath.
- Undefined: divider logic is removed. Opcode 111 completes with latency 1, output_0=0, output_hi=0, div0_flag=1 (illegal-op indication). MUL is unaffected.

Decomposition:
- alu_pkg (shared include): opcode localparams OP_OR..OP_DIV, state encodings ST_IDLE/ST_ITER, flag bit indices.
- Sub-module alu_muldiv_iter: holds the 2N-bit accumulator/remainder, counter, and step logic.
  - Inputs: start, is_div.
  - Outputs: busy, last, lo, hi.
- alu_mc: handshake, simple-op logic, flag/result registers.

Test Plan (N=32):
- ADD 0xFFFFFFFF+1 -> output_0=0, zero=1, carry=1, done 1 cycle after accept; SUB 5-7 -> 0xFFFFFFFE, negative=1, carry=1.
- CMP 3 vs 6 -> output_0=0xFFFFFFFF, negative=1, zero=0; CMP 9 vs 9 -> 0, zero=1; CMP 10 vs 2 -> 1, both flags 0.
- MUL 0x10000 * 0x30000 -> output_hi=3, output_0=0; done exactly 33 cycles after accept; in_ready low for 32 cycles; in_valid held during busy is ignored.
- DIV 100/7 -> output_0=14, output_hi=2, latency 33. DIV 5/0 -> 0xFFFFFFFF, output_hi=5, div0=1, latency 1. Without ALU_DIV_EN: 100/7 -> 0,0, div0=1, latency 1.
- Back-to-back: OR, XOR, AND issued on consecutive cycles -> three consecutive done pulses with the correct results. MUL accepted in its done cycle -> no gap.
- Reset asserted 10 cycles into a MUL -> no done, outputs 0, in_ready=1 one cycle after reset drops; the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and flag bit positions for the multi-cycle ALU.
// Divider support is selected by the ALU_DIV_EN macro in alu_mc and alu_muldiv_iter.
package alu_pkg;

  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  // Flag vector layout: {zero, negative, carry, div0}
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DIV0  = 0;
  localparam int NUM_FLAGS  = 4;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one 2N-bit accumulator.
// Divide steps exist only when ALU_DIV_EN is defined; otherwise is_div is ignored.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter  int N     = 32,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_div,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         busy,
  output logic         last,
  output logic [N-1:0] lo,
  output logic [N-1:0] hi
);

  logic [N-1:0]     acc_lo_q;
  logic [N-1:0]     acc_hi_q;
  logic [N-1:0]     opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N:0]       sum;
  logic [N-1:0]     nxt_lo;
  logic [N-1:0]     nxt_hi;

`ifdef ALU_DIV_EN
  logic       div_q;
  logic [N:0] shifted;
`else
  logic unused_div;
  assign unused_div = is_div;
`endif

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == CNT_W'(1));
  // lo/hi present the post-step value so the top can capture it on the final edge
  assign lo   = nxt_lo;
  assign hi   = nxt_hi;

  always_comb begin
    sum    = '0;
    nxt_lo = acc_lo_q;
    nxt_hi = acc_hi_q;
`ifdef ALU_DIV_EN
    shifted = {acc_hi_q, acc_lo_q[N-1]};
    if (div_q) begin
      sum = shifted - {1'b0, opnd_q};
      if (shifted >= {1'b0, opnd_q}) begin
        nxt_hi = sum[N-1:0];
        nxt_lo = {acc_lo_q[N-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[N-1:0];
        nxt_lo = {acc_lo_q[N-2:0], 1'b0};
      end
    end else begin
`endif
      sum = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opnd_q}) : {1'b0, acc_hi_q};
      {nxt_hi, nxt_lo} = {sum, acc_lo_q[N-1:1]};
`ifdef ALU_DIV_EN
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
`ifdef ALU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (start) begin
      cnt_q    <= CNT_W'(N);
      acc_hi_q <= '0;
`ifdef ALU_DIV_EN
      div_q    <= is_div;
      acc_lo_q <= is_div ? op_a : op_b;
      opnd_q   <= is_div ? op_b : op_a;
`else
      acc_lo_q <= op_b;
      opnd_q   <= op_a;
`endif
    end else if (busy) begin
      cnt_q    <= cnt_q - CNT_W'(1);
      acc_lo_q <= nxt_lo;
      acc_hi_q <= nxt_hi;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready issue, single-cycle logic/arith ops, iterative MUL/DIV.
// Define ALU_DIV_EN to build the divider; without it opcode 111 reports an illegal op.
//
// state   | meaning
// ST_IDLE | ready; simple ops complete here at one op per cycle
// ST_ITER | MUL/DIV stepping, one step per clock, requests ignored
module alu_mc
  import alu_pkg::*;
#(
  parameter  int N     = 32,
  localparam int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alu_op,
  input  logic [N-1:0] input_1,
  input  logic [N-1:0] input_2,
  output logic [N-1:0] output_0,
  output logic [N-1:0] output_hi,
  output logic         done,
  output logic         zero_flag,
  output logic         negative_flag,
  output logic         carry_flag,
  output logic         div0_flag
);

  state_t               state_q, state_d;
  logic [N-1:0]         res_lo_q, res_lo_d;
  logic [N-1:0]         res_hi_q, res_hi_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 done_q, done_d;
  logic                 start_iter;
  logic                 accept;
  logic [N:0]           sum;
  logic                 iter_busy;
  logic                 iter_last;
  logic [N-1:0]         iter_lo;
  logic [N-1:0]         iter_hi;

  assign in_ready      = (state_q == ST_IDLE);
  assign accept        = in_valid & in_ready;
  assign output_0      = res_lo_q;
  assign output_hi     = res_hi_q;
  assign done          = done_q;
  assign zero_flag     = flags_q[FLAG_ZERO];
  assign negative_flag = flags_q[FLAG_NEG];
  assign carry_flag    = flags_q[FLAG_CARRY];
  assign div0_flag     = flags_q[FLAG_DIV0];

  alu_muldiv_iter #(.N(N)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start_iter),
    .is_div (alu_op == OP_DIV),
    .op_a   (input_1),
    .op_b   (input_2),
    .busy   (iter_busy),
    .last   (iter_last),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  always_comb begin
    state_d    = state_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    start_iter = 1'b0;
    sum        = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d   = 1'b1;
          res_hi_d = '0;
          flags_d  = '0;
          unique case (alu_op)
            OP_OR:  res_lo_d = input_1 | input_2;
            OP_ADD: begin
              sum                 = {1'b0, input_1} + {1'b0, input_2};
              res_lo_d            = sum[N-1:0];
              flags_d[FLAG_CARRY] = sum[N];
            end
            OP_SUB: begin
              sum                 = {1'b0, input_1} - {1'b0, input_2};
              res_lo_d            = sum[N-1:0];
              flags_d[FLAG_CARRY] = sum[N];
            end
            // 0 / all-ones / 1 encoding makes the generic zero/negative flags equal eq/lt
            OP_CMP: res_lo_d = (input_1 == input_2) ? '0 :
                               (input_1 <  input_2) ? '1 : N'(1);
            OP_AND: res_lo_d = input_1 & input_2;
            OP_XOR: res_lo_d = input_1 ^ input_2;
            OP_MUL: begin
              done_d     = 1'b0;
              res_hi_d   = res_hi_q;
              flags_d    = flags_q;
              start_iter = 1'b1;
              state_d    = ST_ITER;
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
              if (input_2 == '0) begin
                res_lo_d           = '1;
                res_hi_d           = input_1;
                flags_d[FLAG_DIV0] = 1'b1;
              end else begin
                done_d     = 1'b0;
                res_hi_d   = res_hi_q;
                flags_d    = flags_q;
                start_iter = 1'b1;
                state_d    = ST_ITER;
              end
`else
              res_lo_d           = '0;
              flags_d[FLAG_DIV0] = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_ITER: begin
        if (iter_busy && iter_last) begin
          done_d   = 1'b1;
          res_lo_d = iter_lo;
          res_hi_d = iter_hi;
          flags_d  = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done_d) begin
      flags_d[FLAG_ZERO] = (res_lo_d == '0);
      flags_d[FLAG_NEG]  = res_lo_d[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (N=32); DIV expectations follow ALU_DIV_EN.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [N-1:0] input_1;
  logic [N-1:0] input_2;
  logic [N-1:0] output_0;
  logic [N-1:0] output_hi;
  logic         done;
  logic         zero_flag;
  logic         negative_flag;
  logic         carry_flag;
  logic         div0_flag;

  int checks = 0;
  int errors = 0;
  int lat;
  int low;
  int seen;

  alu_mc #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .input_1       (input_1),
    .input_2       (input_2),
    .output_0      (output_0),
    .output_hi     (output_hi),
    .done          (done),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .carry_flag    (carry_flag),
    .div0_flag     (div0_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {zero_flag, negative_flag, carry_flag, div0_flag};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    input_1  = a;
    input_2  = b;
  endtask

  // Waits (bounded) for done; lat counts edges from the accept edge inclusive.
  task automatic wait_done(output int l, output int lo_cnt);
    l = 1;
    lo_cnt = 0;
    while (done !== 1'b1 && l < 100) begin
      if (in_ready === 1'b0) lo_cnt++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        output int l, output int lo_cnt);
    drive(op, a, b);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(l, lo_cnt);
  endtask

  task automatic chk_res(input string tag, input int l, input int exp_l,
                         input logic [N-1:0] lo, input logic [N-1:0] hi, input logic [3:0] fl);
    chk({tag, "_lat"}, l, exp_l);
    chk({tag, "_lo"}, output_0, lo);
    chk({tag, "_hi"}, output_hi, hi);
    chk({tag, "_flags"}, flags(), fl);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    alu_op   = '0;
    input_1  = '0;
    input_2  = '0;
    repeat (3) @(negedge clk);
    chk("rst_lo", output_0, 0);
    chk("rst_hi", output_hi, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags(), 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat, low);
    chk_res("add_wrap", lat, 1, 32'h0, 32'h0, 4'b1010);
    @(negedge clk);
    chk("add_done_pulse", done, 0);

    run_op(OP_SUB, 32'd5, 32'd7, lat, low);
    chk_res("sub_borrow", lat, 1, 32'hFFFF_FFFE, 32'h0, 4'b0110);

    run_op(OP_CMP, 32'd3, 32'd6, lat, low);
    chk_res("cmp_lt", lat, 1, 32'hFFFF_FFFF, 32'h0, 4'b0100);
    run_op(OP_CMP, 32'd9, 32'd9, lat, low);
    chk_res("cmp_eq", lat, 1, 32'h0, 32'h0, 4'b1000);
    run_op(OP_CMP, 32'd10, 32'd2, lat, low);
    chk_res("cmp_gt", lat, 1, 32'h1, 32'h0, 4'b0000);

    // back-to-back simple ops, one per cycle
    drive(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    @(negedge clk);
    chk("b2b_or_done", done, 1);
    chk("b2b_or", output_0, 32'hF0F0_0F0F);
    drive(OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    @(negedge clk);
    chk("b2b_xor_done", done, 1);
    chk("b2b_xor", output_0, 32'hF00F_F00F);
    drive(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
    @(negedge clk);
    chk("b2b_and_done", done, 1);
    chk("b2b_and", output_0, 32'h0F00_0F00);
    chk("b2b_and_flags", flags(), 4'b0000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_done", done, 0);

    // MUL with a competing request held valid throughout the busy window
    drive(OP_MUL, 32'h0001_0000, 32'h0003_0000);
    @(negedge clk);
    chk("mul_busy_done", done, 0);
    drive(OP_ADD, 32'd1, 32'd1);
    wait_done(lat, low);
    chk_res("mul_big", lat, 33, 32'h0, 32'h3, 4'b1000);
    chk("mul_ready_low", low, 32);
    chk("mul_done_ready", in_ready, 1);

    // next MUL accepted in the done cycle
    drive(OP_MUL, 32'd7, 32'd6);
    @(negedge clk);
    in_valid = 1'b0;
    chk("chain_ready", in_ready, 0);
    chk("chain_done", done, 0);
    wait_done(lat, low);
    chk_res("mul_chain", lat, 33, 32'd42, 32'h0, 4'b0000);

    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, low);
    chk_res("mul_max", lat, 33, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0000);

`ifdef ALU_DIV_EN
    run_op(OP_DIV, 32'd100, 32'd7, lat, low);
    chk_res("div_100_7", lat, 33, 32'd14, 32'd2, 4'b0000);
    run_op(OP_DIV, 32'hFFFF_FFFF, 32'd16, lat, low);
    chk_res("div_max_16", lat, 33, 32'h0FFF_FFFF, 32'hF, 4'b0000);
    run_op(OP_DIV, 32'd5, 32'd0, lat, low);
    chk_res("div_zero", lat, 1, 32'hFFFF_FFFF, 32'd5, 4'b0101);
`else
    run_op(OP_DIV, 32'd100, 32'd7, lat, low);
    chk_res("div_off", lat, 1, 32'h0, 32'h0, 4'b1001);
`endif

    run_op(OP_MUL, 32'd3, 32'd5, lat, low);
    chk_res("mul_pre_rst", lat, 33, 32'd15, 32'h0, 4'b0000);

    // reset ten cycles into a MUL
    drive(OP_MUL, 32'd5, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", in_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_lo", output_0, 0);
    chk("abort_hi", output_hi, 0);
    chk("abort_flags", flags(), 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);

    run_op(OP_ADD, 32'd2, 32'd3, lat, low);
    chk_res("add_after_abort", lat, 1, 32'd5, 32'h0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
